// File: rtl/prism_node_mem.sv
// Node SRAM responder for one PRISM-PIFO tree-level engine: clear sweep after reset,
// 2-cycle read pipeline with write-first forwarding. Optional parity: PRISM_NODE_MEM_PARITY_EN.
module prism_node_mem #(
   parameter int PTW   = 16,
   parameter int MTW   = 32,
   parameter int CTW   = 10,
   parameter int ADW   = 20,
   parameter int DEPTH = 341
) (
   input  logic                         i_clk,
   input  logic                         i_arst_n,
   input  logic                         i_rd_en,
   input  logic [ADW-1:0]               i_rd_addr,
   output logic [4*(CTW+MTW+PTW)-1:0]   o_rd_data,
   input  logic                         i_wr_en,
   input  logic [ADW-1:0]               i_wr_addr,
   input  logic [4*(CTW+MTW+PTW)-1:0]   i_wr_data,
   output logic                         o_init_done,
   output logic                         o_err,
   output logic                         o_par_err
);
   localparam int SW = CTW + MTW + PTW;
   localparam int NW = 4 * SW;
   localparam int AW = $clog2(DEPTH);
   localparam logic [SW-1:0] EMPTY      = {{CTW{1'b0}}, {MTW{1'b0}}, {PTW{1'b1}}};
   localparam logic [NW-1:0] EMPTY_NODE = {4{EMPTY}};

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   // Request semantics: i_rd_en / i_wr_en are valid-only strobes; there is no ready,
   // every request presented while running is consumed on the edge that samples it.
   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [NW-1:0]   mem [DEPTH];

   logic            run, rd_ok, wr_ok, rd_acc, wr_acc, rd_fwd, s1_hit;
   logic [AW-1:0]   rd_idx, wr_idx, mem_wa;
   logic            mem_we;
   logic [NW-1:0]   mem_wd, rd_word;
   logic            s1_vld;
   logic [ADW-1:0]  s1_addr;
   logic [NW-1:0]   s1_data;
   logic            par_bad;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_INIT: begin
            if (ptr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
            else                          ptr_d   = ptr_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign run    = (state_q == ST_RUN);
   assign rd_ok  = (i_rd_addr < ADW'(DEPTH));
   assign wr_ok  = (i_wr_addr < ADW'(DEPTH));
   assign rd_acc = run & i_rd_en;
   assign wr_acc = run & i_wr_en & wr_ok;
   assign rd_idx = i_rd_addr[AW-1:0];
   assign wr_idx = i_wr_addr[AW-1:0];

   // The sweep owns the single write port until the FSM reaches RUN.
   assign mem_we = !run | wr_acc;
   assign mem_wa = run ? wr_idx : ptr_q;
   assign mem_wd = run ? i_wr_data : EMPTY_NODE;

   always_ff @(posedge i_clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   assign rd_fwd  = wr_acc && (i_wr_addr == i_rd_addr);
   assign rd_word = rd_fwd ? i_wr_data : (rd_ok ? mem[rd_idx] : EMPTY_NODE);
   // An out-of-range stage-1 address can never match, since such writes are never accepted.
   assign s1_hit  = s1_vld && wr_acc && (i_wr_addr == s1_addr);

`ifdef PRISM_NODE_MEM_PARITY_EN
   logic par_mem [DEPTH];
   logic rd_par, s1_par;

   always_ff @(posedge i_clk) begin
      if (mem_we) par_mem[mem_wa] <= ^mem_wd;
   end

   assign rd_par = rd_fwd ? ^i_wr_data : (rd_ok ? par_mem[rd_idx] : ^EMPTY_NODE);

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n)   s1_par <= 1'b0;
      else if (rd_acc) s1_par <= rd_par;
   end

   assign par_bad = s1_vld && !s1_hit && ((^s1_data) != s1_par);
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         s1_vld      <= 1'b0;
         s1_addr     <= '0;
         s1_data     <= EMPTY_NODE;
         o_rd_data   <= EMPTY_NODE;
         o_par_err   <= 1'b0;
         o_init_done <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         s1_vld      <= rd_acc;
         o_par_err   <= par_bad;
         o_init_done <= run;
         if (rd_acc) begin
            s1_addr <= i_rd_addr;
            s1_data <= rd_word;
         end
         if (s1_vld) o_rd_data <= s1_hit ? i_wr_data : s1_data;
         if ((!run && (i_rd_en || i_wr_en)) || (rd_acc && !rd_ok) ||
             (run && i_wr_en && !wr_ok) || par_bad)
            o_err <= 1'b1;
      end
   end
endmodule
